// File: rtl/spi_sclk_burst_gen.sv
// spi_sclk_burst_gen
// Gated SPI SCLK burst generator with programmable half-period, burst
// length and CPOL/CPHA mode. Emits one-cycle sample/shift strobes that are
// registered on the same clkin edge as the matching sclk toggle.
// Optional feature macro: SPI_SCLK_ABORT_EN adds an abort input and an
// aborted pulse output that cancel a running burst.
module spi_sclk_burst_gen #(
    parameter int DIV_W = 8,
    parameter int NB_W  = 6
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic [NB_W-1:0]  nbits,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             start,
`ifdef SPI_SCLK_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             sclk,
    output logic             sample_stb,
    output logic             shift_stb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] CNT_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [NB_W:0]    EDGE_ZERO = {(NB_W+1){1'b0}};
    localparam logic [NB_W:0]    EDGE_ONE  = {{NB_W{1'b0}}, 1'b1};
    localparam logic [NB_W-1:0]  NB_ZERO   = {NB_W{1'b0}};

    state_t           state_r, state_s;
    logic [DIV_W-1:0] cnt_r, cnt_s;
    logic [NB_W:0]    edge_r, edge_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [NB_W-1:0]  nbits_r, nbits_s;
    logic             cpol_r, cpol_s;
    logic             cpha_r, cpha_s;
    logic             sclk_r, sclk_s;
    logic             sample_r, sample_s;
    logic             shift_r, shift_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             aborted_r, aborted_s;

    logic             half_end_s;
    logic             lead_s;
    logic             last_s;
    logic [NB_W:0]    edge_inc_s;

    // Half-period expiry, parity of the upcoming SCLK edge and last-edge detect
    assign half_end_s = (cnt_r == div_r);
    assign edge_inc_s = edge_r + EDGE_ONE;
    assign lead_s     = edge_inc_s[0];
    assign last_s     = (edge_inc_s == {nbits_r, 1'b0});

    // Next-state and next-output logic for the burst FSM
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        edge_s    = edge_r;
        div_s     = div_r;
        nbits_s   = nbits_r;
        cpol_s    = cpol_r;
        cpha_s    = cpha_r;
        sclk_s    = sclk_r;
        sample_s  = 1'b0;
        shift_s   = 1'b0;
        busy_s    = busy_r;
        done_s    = 1'b0;
        aborted_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Idle level tracks cpol with one cycle of latency.
                sclk_s = cpol;
                if (start && (nbits != NB_ZERO)) begin
                    state_s = ST_SETUP;
                    cnt_s   = CNT_ZERO;
                    edge_s  = EDGE_ZERO;
                    div_s   = div;
                    nbits_s = nbits;
                    cpol_s  = cpol;
                    cpha_s  = cpha;
                    sclk_s  = cpol;
                    busy_s  = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_SETUP, ST_RUN: begin
                // The SETUP half-period ends with edge 1, so both states
                // share the toggle path; RUN counts the remaining edges.
                if (half_end_s) begin
                    cnt_s    = CNT_ZERO;
                    sclk_s   = ~sclk_r;
                    edge_s   = edge_inc_s;
                    sample_s = (lead_s != cpha_r);
                    shift_s  = (lead_s == cpha_r);
                    if (last_s) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (half_end_s) begin
                    cnt_s   = CNT_ZERO;
                    edge_s  = EDGE_ZERO;
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                edge_s  = EDGE_ZERO;
                busy_s  = 1'b0;
            end
        endcase

`ifdef SPI_SCLK_ABORT_EN
        // Abort cancels a running burst without a done pulse.
        if (abort && busy_r) begin
            state_s   = ST_IDLE;
            cnt_s     = CNT_ZERO;
            edge_s    = EDGE_ZERO;
            sclk_s    = cpol_r;
            sample_s  = 1'b0;
            shift_s   = 1'b0;
            busy_s    = 1'b0;
            done_s    = 1'b0;
            aborted_s = 1'b1;
        end else begin
            aborted_s = 1'b0;
        end
`endif
    end

    // State, counters, latched configuration and registered outputs
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            edge_r    <= EDGE_ZERO;
            div_r     <= CNT_ZERO;
            nbits_r   <= NB_ZERO;
            cpol_r    <= 1'b0;
            cpha_r    <= 1'b0;
            sclk_r    <= 1'b0;
            sample_r  <= 1'b0;
            shift_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            edge_r    <= edge_s;
            div_r     <= div_s;
            nbits_r   <= nbits_s;
            cpol_r    <= cpol_s;
            cpha_r    <= cpha_s;
            sclk_r    <= sclk_s;
            sample_r  <= sample_s;
            shift_r   <= shift_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            aborted_r <= aborted_s;
        end
    end

    assign sclk       = sclk_r;
    assign sample_stb = sample_r;
    assign shift_stb  = shift_r;
    assign busy       = busy_r;
    assign done       = done_r;
`ifdef SPI_SCLK_ABORT_EN
    assign aborted    = aborted_r;
`endif

endmodule

// File: tb/tb_spi_sclk_burst_gen.sv
// Self-checking bench for spi_sclk_burst_gen: a table of burst vectors
// with expected done offset and edge count, a per-burst scoreboard queue of
// expected SCLK edges, plus hand sequences for reset, nbits=0, back-to-back
// starts and (with SPI_SCLK_ABORT_EN) abort.
module tb_spi_sclk_burst_gen;

    localparam int DIV_W = 8;
    localparam int NB_W  = 6;

    logic             clkin = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] div;
    logic [NB_W-1:0]  nbits;
    logic             cpol;
    logic             cpha;
    logic             start;
    logic             sclk;
    logic             sample_stb;
    logic             shift_stb;
    logic             busy;
    logic             done;
`ifdef SPI_SCLK_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] div;
        logic [5:0] nbits;
        logic       cpol;
        logic       cpha;
        logic       perturb;
        int         exp_done;
        int         exp_edges;
    } vec_t;

    typedef struct {
        int   cyc;
        logic sclk;
        logic sample;
        logic shift;
    } ev_t;

    vec_t vecs[7];

    spi_sclk_burst_gen #(.DIV_W(DIV_W), .NB_W(NB_W)) dut (
        .clkin      (clkin),
        .reset      (reset),
        .div        (div),
        .nbits      (nbits),
        .cpol       (cpol),
        .cpha       (cpha),
        .start      (start),
`ifdef SPI_SCLK_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .sclk       (sclk),
        .sample_stb (sample_stb),
        .shift_stb  (shift_stb),
        .busy       (busy),
        .done       (done)
    );

    always #5 clkin = ~clkin;

    always @(posedge clkin) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        ev_t  q[$];
        ev_t  x;
        int   h;
        int   t0;
        int   tdone;
        int   nsam;
        int   nshf;
        logic prev;
        @(negedge clkin);
        div = v.div; nbits = v.nbits; cpol = v.cpol; cpha = v.cpha; start = 1'b0;
        @(negedge clkin);
        @(negedge clkin);
        chk("idle_level", int'(sclk), int'(v.cpol));
        chk("idle_busy", int'(busy), 0);
        start = 1'b1;
        t0    = cyc + 1;
        h     = int'(v.div) + 1;
        tdone = t0 + v.exp_done;
        for (int k = 1; k <= 2 * int'(v.nbits); k++) begin
            x.cyc    = t0 + k * h;
            x.sclk   = v.cpol ^ k[0];
            x.sample = (k[0] != v.cpha);
            x.shift  = (k[0] == v.cpha);
            q.push_back(x);
        end
        prev = sclk;
        nsam = 0;
        nshf = 0;
        for (int e = t0; e <= tdone + 1; e++) begin
            @(negedge clkin);
            if (e == t0) start = 1'b0;
            if (v.perturb && e == t0 + h + 1) begin
                start = 1'b1;
                div   = ~v.div;
                nbits = v.nbits + 6'd3;
                cpol  = ~v.cpol;
                cpha  = ~v.cpha;
            end
            if (v.perturb && e == t0 + h + 2) start = 1'b0;
            if (e <= tdone) begin
                chk("busy", int'(busy), int'(e < tdone));
                chk("done", int'(done), int'(e == tdone));
                if (sclk !== prev || sample_stb || shift_stb) begin
                    if (sample_stb) nsam++;
                    if (shift_stb) nshf++;
                    chk("edge_pending", int'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        x = q.pop_front();
                        chk("edge_cycle", e - t0, x.cyc - t0);
                        chk("edge_sclk", int'(sclk), int'(x.sclk));
                        chk("edge_sample", int'(sample_stb), int'(x.sample));
                        chk("edge_shift", int'(shift_stb), int'(x.shift));
                    end
                end
                prev = sclk;
            end else begin
                chk("follow_cpol", int'(sclk), int'(cpol));
            end
        end
        chk("edges_left", q.size(), 0);
        chk("n_sample", nsam, v.exp_edges / 2);
        chk("n_shift", nshf, v.exp_edges / 2);
    endtask

    initial begin
        int t0;
        int exp_busy[5];
        int exp_done[5];

        // {div, nbits, cpol, cpha, perturb, done offset, sclk edges}
        vecs[0] = '{8'd4,   6'd8,  1'b0, 1'b0, 1'b0, 85,  16};
        vecs[1] = '{8'd0,   6'd1,  1'b1, 1'b1, 1'b0, 3,   2};
        vecs[2] = '{8'd2,   6'd3,  1'b1, 1'b0, 1'b0, 21,  6};
        vecs[3] = '{8'd0,   6'd63, 1'b0, 1'b1, 1'b0, 127, 126};
        vecs[4] = '{8'd255, 6'd1,  1'b0, 1'b0, 1'b0, 768, 2};
        vecs[5] = '{8'd4,   6'd8,  1'b0, 1'b0, 1'b1, 85,  16};
        vecs[6] = '{8'd1,   6'd5,  1'b1, 1'b1, 1'b0, 22,  10};

        reset = 1'b1; start = 1'b0; div = 8'd3; nbits = 6'd2; cpol = 1'b1; cpha = 1'b0;
`ifdef SPI_SCLK_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clkin);
        start = 1'b1;
        @(negedge clkin);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_sample", int'(sample_stb), 0);
        chk("rst_shift", int'(shift_stb), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
`ifdef SPI_SCLK_ABORT_EN
        chk("rst_aborted", int'(aborted), 0);
`endif
        start = 1'b0;
        reset = 1'b0;

        // start with nbits=0 must be ignored
        cpol = 1'b0; nbits = 6'd0; div = 8'd0;
        @(negedge clkin);
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clkin);
            chk("nb0_busy", int'(busy), 0);
            chk("nb0_sclk", int'(sclk), 0);
        end
        start = 1'b0;

        for (int i = 0; i < 7; i++) run_burst(vecs[i]);

        // start held high: not accepted in the done cycle, accepted right after
        @(negedge clkin);
        div = 8'd0; nbits = 6'd1; cpol = 1'b1; cpha = 1'b1;
        exp_busy = '{1, 1, 1, 0, 1};
        exp_done = '{0, 0, 0, 1, 0};
        @(negedge clkin);
        @(negedge clkin);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clkin);
            chk("b2b_busy", int'(busy), exp_busy[i]);
            chk("b2b_done", int'(done), exp_done[i]);
        end
        start = 1'b0;
        repeat (6) @(negedge clkin);
        chk("b2b_idle", int'(busy), 0);

        // reset in the middle of a burst: everything clears, no done pulse
        div = 8'd4; nbits = 6'd8; cpol = 1'b0; cpha = 1'b0;
        @(negedge clkin);
        @(negedge clkin);
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clkin);
        start = 1'b0;
        while (cyc < t0 + 22) @(negedge clkin);
        reset = 1'b1;
        @(negedge clkin);
        reset = 1'b0;
        chk("mrst_sclk", int'(sclk), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_sample", int'(sample_stb), 0);
        chk("mrst_shift", int'(shift_stb), 0);
        for (int i = 0; i < 70; i++) begin
            @(negedge clkin);
            chk("mrst_no_done", int'(done), 0);
            chk("mrst_no_busy", int'(busy), 0);
        end

`ifdef SPI_SCLK_ABORT_EN
        // abort at T0+12: burst cancelled, aborted pulse, restart next cycle
        @(negedge clkin);
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clkin);
        start = 1'b0;
        while (cyc < t0 + 11) @(negedge clkin);
        abort = 1'b1;
        @(negedge clkin);
        abort = 1'b0;
        chk("abt_busy", int'(busy), 0);
        chk("abt_aborted", int'(aborted), 1);
        chk("abt_sclk", int'(sclk), 0);
        chk("abt_done", int'(done), 0);
        start = 1'b1;
        @(negedge clkin);
        start = 1'b0;
        chk("abt_restart_busy", int'(busy), 1);
        chk("abt_aborted_clr", int'(aborted), 0);
        chk("abt_done2", int'(done), 0);
        reset = 1'b1;
        @(negedge clkin);
        reset = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
